// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding decode through a 2-entry {pc, inst} FIFO
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_rom_req_o/addr_o       ROM fetch request and address (held until rom_ack_i)
//   rom_ack_i/rom_inst_i      ROM acknowledge and instruction word
//   ex_jump_en_i/addr_i       redirect from execute (flushes FIFO, retargets fetch)
//   id_ready_i                decode accepts the head entry
//   if_valid_o/pc_o/inst_o    head entry toward if_id_reg
//   if_misalign_o             misaligned-redirect flag, only with IF_MISALIGN_EXC_EN
// Optional feature macro: IF_MISALIGN_EXC_EN (trap misaligned redirects and halt fetch)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_rom_req_o,
    output logic [31:0] if_rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_inst_i,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
`ifdef IF_MISALIGN_EXC_EN
    ,
    output logic        if_misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0] pc_mem_q [2];
    logic [31:0] inst_mem_q [2];
    logic        push, pop, halted;
    logic [31:0] jump_tgt;
`ifdef IF_MISALIGN_EXC_EN
    logic        misalign_q, misalign_d;
    assign jump_tgt      = ex_jump_addr_i;
    assign halted        = misalign_q;
    assign misalign_d    = ex_jump_en_i ? (ex_jump_addr_i[1:0] != 2'b00) : misalign_q;
    assign if_misalign_o = misalign_q;
`else
    assign jump_tgt = ex_jump_addr_i & ~32'h3;
    assign halted   = 1'b0;
`endif
    assign if_valid_o    = count_q != 2'd0;
    assign if_rom_req_o  = state_q != IDLE;
    // A redirect while a request is outstanding must not disturb the ROM address,
    // so the issued address is held separately from fetch_pc.
    assign if_rom_addr_o = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    assign if_pc_o       = if_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign if_inst_o     = if_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    // A redirect cancels both the incoming word and the consumer handshake.
    assign push = (state_q == WAIT) && rom_ack_i && !ex_jump_en_i;
    assign pop  = if_valid_o && id_ready_i && !ex_jump_en_i;
    always_comb begin
        count_d    = ex_jump_en_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d   = ex_jump_en_i ? 1'b0 : rd_ptr_q ^ pop;
        wr_ptr_d   = ex_jump_en_i ? 1'b0 : wr_ptr_q ^ push;
        fetch_pc_d = ex_jump_en_i ? jump_tgt : fetch_pc_q + (push ? 32'd4 : 32'd0);
        state_d    = state_q;
        case (state_q)
            IDLE:    state_d = (!ex_jump_en_i && !halted && count_d != 2'd2) ? WAIT : IDLE;
            WAIT:    state_d = ex_jump_en_i ? (rom_ack_i ? IDLE : DROP)
                                            : ((rom_ack_i && count_d == 2'd2) ? IDLE : WAIT);
            DROP:    state_d = rom_ack_i ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
        req_addr_d = (state_d == WAIT) ? fetch_pc_d : req_addr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef IF_MISALIGN_EXC_EN
            misalign_q <= misalign_d;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= rom_inst_i;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage with a latency-varying ROM model
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_rom_req_o;
    logic [31:0] if_rom_addr_o;
    logic        rom_ack_i = 1'b0;
    logic [31:0] rom_inst_i = 32'h0;
    logic        ex_jump_en_i = 1'b0;
    logic [31:0] ex_jump_addr_i = 32'h0;
    logic        id_ready_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
`ifdef IF_MISALIGN_EXC_EN
    logic        if_misalign_o;
`endif
    always #5 clk = ~clk;
    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .if_rom_req_o(if_rom_req_o),
        .if_rom_addr_o(if_rom_addr_o),
        .rom_ack_i(rom_ack_i),
        .rom_inst_i(rom_inst_i),
        .ex_jump_en_i(ex_jump_en_i),
        .ex_jump_addr_i(ex_jump_addr_i),
        .id_ready_i(id_ready_i),
        .if_valid_o(if_valid_o),
        .if_pc_o(if_pc_o),
        .if_inst_o(if_inst_o)
`ifdef IF_MISALIGN_EXC_EN
        , .if_misalign_o(if_misalign_o)
`endif
    );
    ent_t        exp_q[$];
    ent_t        mon_e;
    logic [31:0] pop_log[$];
    int          pop_cyc[$];
    int          total = 0, bad = 0, cyc = 0, idle = 0;
    int          lat = 0, wcnt = 0;
    logic        lat_rand = 1'b0, rdy = 1'b1, jmp = 1'b0, rst_k = 1'b1;
    logic        trig_en = 1'b0, req_seen = 1'b0, saw_pc8 = 1'b0;
    logic [31:0] jmp_addr = 32'h0, trig_addr = 32'h0, held_addr = 32'h0, next_pc = 32'h0;
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction
    function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IF_MISALIGN_EXC_EN
        return a;
`else
        return a & ~32'h3;
`endif
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic chk_true(input string name, input logic cond);
        total++;
        if (cond !== 1'b1) begin
            bad++;
            $display("FAIL %s: got %b want 1", name, cond);
        end
    endtask
    task automatic chk_log(input int i, input logic [31:0] exp);
        if (i < pop_log.size()) chk($sformatf("pop_pc[%0d]", i), pop_log[i], exp);
        else chk_true($sformatf("pop_count>%0d", i), 1'b0);
    endtask
    // One clock of stimulus: ROM responder, decode/redirect/reset drive, expected-stream upkeep.
    task automatic cycle();
        logic ack;
        @(negedge clk);
        cyc++;
        ack = 1'b0;
        if (if_rom_req_o && !rst_k) begin
            if (req_seen) chk("rom_addr_stable", if_rom_addr_o, held_addr);
            held_addr = if_rom_addr_o;
            req_seen  = 1'b1;
            ack       = wcnt >= lat;
            wcnt      = ack ? 0 : wcnt + 1;
        end else begin
            req_seen = 1'b0;
            wcnt     = 0;
        end
        if (ack) begin
            req_seen = 1'b0;
            if (lat_rand) lat = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 2);
            if (trig_en && if_rom_addr_o == trig_addr) begin
                jmp     = 1'b1;
                trig_en = 1'b0;
            end
        end
        rst            = rst_k;
        rom_ack_i      = ack;
        rom_inst_i     = ack ? rom_word(if_rom_addr_o) : $urandom;
        id_ready_i     = rdy;
        ex_jump_en_i   = jmp;
        ex_jump_addr_i = jmp_addr;
        if (rst_k) begin
            exp_q.delete();
            next_pc = RESET_PC;
        end else if (jmp) begin
            exp_q.delete();
            next_pc = tgt(jmp_addr);
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back({next_pc, rom_word(next_pc)});
            next_pc += 32'd4;
        end
        jmp = 1'b0;
    endtask
    task automatic do_reset();
        rst_k = 1'b1;
        cycle();
        cycle();
        chk("rst_req", {31'b0, if_rom_req_o}, 32'h0);
        chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);
`ifdef IF_MISALIGN_EXC_EN
        chk("rst_misalign", {31'b0, if_misalign_o}, 32'h0);
`endif
        pop_log.delete();
        pop_cyc.delete();
        saw_pc8 = 1'b0;
        rst_k   = 1'b0;
    endtask
    // Monitor: samples just before each rising edge, pops the scoreboard on every accepted entry.
    initial forever begin
        @(negedge clk);
        #4;
        if (!rst && if_valid_o && if_pc_o == 32'h8) saw_pc8 = 1'b1;
        if (!rst && if_rom_req_o && rom_ack_i) chk_true("no_push_when_full", dut.count_q != 2'd2);
        if (!rst && if_valid_o && id_ready_i && !ex_jump_en_i) begin
            idle = 0;
            pop_log.push_back(if_pc_o);
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk_true("scoreboard_underflow", 1'b0);
            else begin
                mon_e = exp_q.pop_front();
                chk("head_pc", if_pc_o, mon_e.pc);
                chk("head_inst", if_inst_o, mon_e.inst);
            end
        end else if (rst || ex_jump_en_i || !id_ready_i) idle = 0;
        else if (++idle == 80) begin
            chk_true("watchdog_progress", 1'b0);
            idle = 0;
        end
    end
    initial begin
        lat = 0; lat_rand = 1'b0; rdy = 1'b1;
        do_reset();
        cycle();
        cycle();
        chk_true("req_after_reset", if_rom_req_o);
        chk("first_addr", if_rom_addr_o, RESET_PC);
        repeat (8) cycle();
        for (int i = 0; i < 4; i++) chk_log(i, RESET_PC + 32'(4 * i));
        for (int i = 1; i < 4 && i < pop_cyc.size(); i++) chk("pop_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
        rdy = 1'b0;
        do_reset();
        repeat (6) cycle();
        chk("stall_req", {31'b0, if_rom_req_o}, 32'h0);
        chk("stall_valid", {31'b0, if_valid_o}, 32'h1);
        chk("stall_head_pc", if_pc_o, 32'h0);
        chk("stall_head_inst", if_inst_o, rom_word(32'h0));
        rdy = 1'b1;
        repeat (6) cycle();
        for (int i = 0; i < 3; i++) chk_log(i, 32'(4 * i));
        lat = 3;
        do_reset();
        cycle();
        cycle();
        jmp = 1'b1; jmp_addr = 32'h100;
        cycle();
        cycle();
        chk("drop_req", {31'b0, if_rom_req_o}, 32'h1);
        chk("drop_addr_held", if_rom_addr_o, 32'h0);
        repeat (20) cycle();
        chk_log(0, 32'h100);
        lat = 0;
        do_reset();
        trig_en = 1'b1; trig_addr = 32'h8; jmp_addr = 32'h200;
        repeat (15) cycle();
        chk_true("jump_on_ack_fired", !trig_en);
        chk_true("pc8_never_valid", !saw_pc8);
        chk_log(0, 32'h0);
        chk_log(1, 32'h200);
        chk_log(2, 32'h204);
        trig_en = 1'b0;
        lat_rand = 1'b1;
        do_reset();
        jmp = 1'b1; jmp_addr = 32'hFFFF_FFF8;
        repeat (60) cycle();
        chk_log(0, 32'hFFFF_FFF8);
        chk_log(1, 32'hFFFF_FFFC);
        chk_log(2, 32'h0000_0000);
`ifdef IF_MISALIGN_EXC_EN
        do_reset();
        jmp = 1'b1; jmp_addr = 32'h102;
        repeat (7) cycle();
        chk("misalign_set", {31'b0, if_misalign_o}, 32'h1);
        chk("misalign_no_req", {31'b0, if_rom_req_o}, 32'h0);
        chk("misalign_no_valid", {31'b0, if_valid_o}, 32'h0);
        jmp = 1'b1; jmp_addr = 32'h104;
        repeat (40) cycle();
        chk("misalign_cleared", {31'b0, if_misalign_o}, 32'h0);
        chk_log(0, 32'h104);
`else
        do_reset();
        jmp = 1'b1; jmp_addr = 32'h303;
        repeat (40) cycle();
        chk_log(0, 32'h300);
        chk_log(1, 32'h304);
`endif
        do_reset();
        repeat (4000) begin
            rdy = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 24) == 0) begin
                jmp      = 1'b1;
                jmp_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifdef IF_MISALIGN_EXC_EN
                jmp_addr = jmp_addr & ~32'h3;
`endif
            end
            rst_k = $urandom_range(0, 399) == 0;
            cycle();
        end
        rst_k = 1'b0;
        rdy   = 1'b1;
        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
